// File: rtl/reg_wb_queue.sv
// Register write-back queue.
// Merges pipeline W-stage register writes with results from the multiply/divide
// unit into a single register file write port. Pipeline writes always win the
// port. Multiply/divide results wait in a 4-entry FIFO and drain whenever the
// pipeline leaves the port idle. A pipeline write kills every queued entry for
// the same register, so an older result can never overwrite a newer one.
module reg_wb_queue (
  input  logic        clk,
  input  logic        reset,
  // W-stage write request
  input  logic        pipe_we,
  input  logic [4:0]  pipe_addr,
  input  logic [31:0] pipe_data,
  // Multiply/divide result handshake
  input  logic        md_valid,
  input  logic [4:0]  md_addr,
  input  logic [31:0] md_data,
  output logic        md_ready,
  // Register file write port
  output logic        RegWrite,
  output logic [4:0]  Waddr,
  output logic [31:0] WData,
  // D-stage hazard query
  input  logic [4:0]  qry_addr,
  output logic        qry_pending,
  output logic [2:0]  depth
);

  localparam int unsigned QDEPTH = 4;

  // Queue storage: one valid bit, destination register and data per slot.
  logic        valid_q [QDEPTH];
  logic [4:0]  addr_q  [QDEPTH];
  logic [31:0] data_q  [QDEPTH];

  logic [1:0]  head_q;
  logic [1:0]  tail_q;
  logic [2:0]  count_q;
  logic [2:0]  count_d;

  logic        reg_write_q;
  logic [4:0]  waddr_q;
  logic [31:0] wdata_q;

  logic        pipe_req;
  logic        md_push;
  logic        pop;
  logic        qry_hit;

  // Request decode: register 0 is never written, so it counts as no request.
  assign md_ready = (count_q < 3'd4);
  assign pipe_req = pipe_we && (pipe_addr != 5'd0);
  assign md_push  = md_valid && md_ready && (md_addr != 5'd0);
  assign pop      = !pipe_req && (count_q != 3'd0);

  // Occupancy next state; a push and a pop in the same cycle cancel out.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    count_d = count_q;
    if (md_push && !pop) begin
      count_d = count_q + 3'd1;
    end else if (!md_push && pop) begin
      count_d = count_q - 3'd1;
    end
  end

  // Hazard query: only live (non-killed, occupied) entries report pending.
  // Popped slots have their valid bit cleared, so free slots never match.
  always_comb begin
    qry_hit = 1'b0;
    for (int i = 0; i < QDEPTH; i++) begin
      if (valid_q[i] && (addr_q[i] == qry_addr)) begin
        qry_hit = 1'b1;
      end
    end
    qry_pending = qry_hit && (qry_addr != 5'd0);
  end

  // Queue state and registered write-port outputs, updated by priority:
  // pipeline write, then queue drain, then idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q      <= 2'd0;
      tail_q      <= 2'd0;
      count_q     <= 3'd0;
      reg_write_q <= 1'b0;
      waddr_q     <= 5'd0;
      wdata_q     <= 32'd0;
      // NOTE: only the valid bits need a reset value; addr/data of an
      // invalid slot are never observed, so they stay plain storage.
      for (int i = 0; i < QDEPTH; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else begin
      if (pipe_req) begin
        reg_write_q <= 1'b1;
        waddr_q     <= pipe_addr;
        wdata_q     <= pipe_data;
        // Kill older queued results for the register being written now.
        for (int i = 0; i < QDEPTH; i++) begin
          if (addr_q[i] == pipe_addr) begin
            valid_q[i] <= 1'b0;
          end
        end
      end else if (pop) begin
        reg_write_q     <= valid_q[head_q];
        waddr_q         <= addr_q[head_q];
        wdata_q         <= data_q[head_q];
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 2'd1;
      end else begin
        reg_write_q <= 1'b0;
        waddr_q     <= 5'd0;
        wdata_q     <= 32'd0;
      end

      // The push comes after the kill loop so a result accepted alongside a
      // pipeline write to the same register survives as the younger write.
      if (md_push) begin
        valid_q[tail_q] <= 1'b1;
        addr_q[tail_q]  <= md_addr;
        data_q[tail_q]  <= md_data;
        tail_q          <= tail_q + 2'd1;
      end

      count_q <= count_d;
    end
  end

  assign RegWrite = reg_write_q;
  assign Waddr    = waddr_q;
  assign WData    = wdata_q;
  assign depth    = count_q;

endmodule

// File: tb/tb_reg_wb_queue.sv
// Testbench for reg_wb_queue: a queue model acts as scoreboard for the write
// port, plus directed scenarios with fixed expected values.
module tb_reg_wb_queue;

  typedef struct packed {
    logic        v;
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  logic        clk;
  logic        reset;
  logic        pipe_we;
  logic [4:0]  pipe_addr;
  logic [31:0] pipe_data;
  logic        md_valid;
  logic [4:0]  md_addr;
  logic [31:0] md_data;
  logic        md_ready;
  logic        RegWrite;
  logic [4:0]  Waddr;
  logic [31:0] WData;
  logic [4:0]  qry_addr;
  logic        qry_pending;
  logic [2:0]  depth;

  int checks = 0;
  int passed = 0;

  ent_t mq[$];     // model of queue contents
  ent_t exp_q[$];  // expected write-port outputs
  bit   model_ok = 0;

  reg_wb_queue dut (
    .clk         (clk),
    .reset       (reset),
    .pipe_we     (pipe_we),
    .pipe_addr   (pipe_addr),
    .pipe_data   (pipe_data),
    .md_valid    (md_valid),
    .md_addr     (md_addr),
    .md_data     (md_data),
    .md_ready    (md_ready),
    .RegWrite    (RegWrite),
    .Waddr       (Waddr),
    .WData       (WData),
    .qry_addr    (qry_addr),
    .qry_pending (qry_pending),
    .depth       (depth)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of stimulus, check the combinational outputs against the
  // model before the edge, push the expected write, then pop and compare it.
  task automatic step(input logic rst, input logic pwe, input logic [4:0] pa,
                      input logic [31:0] pd, input logic mv, input logic [4:0] ma,
                      input logic [31:0] md, input logic [4:0] qa);
    ent_t out_e;
    ent_t got;
    logic rdy;
    logic pend;
    reset = rst; pipe_we = pwe; pipe_addr = pa; pipe_data = pd;
    md_valid = mv; md_addr = ma; md_data = md; qry_addr = qa;
    #1;
    rdy  = (mq.size() < 4);
    pend = 1'b0;
    foreach (mq[i]) if (mq[i].v && mq[i].a == qa && qa != 5'd0) pend = 1'b1;
    if (model_ok) begin
      checks++;
      if (md_ready !== rdy) $display("FAIL sb_md_ready got %b want %b", md_ready, rdy);
      else passed++;
      checks++;
      if (qry_pending !== pend)
        $display("FAIL sb_qry_pending qry=%0d got %b want %b", qa, qry_pending, pend);
      else passed++;
    end
    // Model update for this edge.
    if (rst) begin
      mq.delete();
      out_e = '0;
    end else begin
      if (pwe && pa != 5'd0) begin
        out_e = '{v: 1'b1, a: pa, d: pd};
        foreach (mq[i]) if (mq[i].a == pa) mq[i].v = 1'b0;
      end else if (mq.size() > 0) begin
        out_e = mq.pop_front();
      end else begin
        out_e = '0;
      end
      if (mv && rdy && ma != 5'd0) mq.push_back('{v: 1'b1, a: ma, d: md});
    end
    exp_q.push_back(out_e);
    @(posedge clk);
    #1;
    if (rst) model_ok = 1;
    out_e = exp_q.pop_front();
    got   = '{v: RegWrite, a: Waddr, d: WData};
    checks++;
    if (got !== out_e)
      $display("FAIL sb_write got we=%b addr=%0d data=%h want we=%b addr=%0d data=%h",
               got.v, got.a, got.d, out_e.v, out_e.a, out_e.d);
    else passed++;
    checks++;
    if (depth !== 3'(mq.size())) $display("FAIL sb_depth got %0d want %0d", depth, mq.size());
    else passed++;
  endtask

  task automatic idle(input logic [4:0] qa);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, qa);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd5);
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd5);
    checks++;
    if (depth !== 3'd0) $display("FAIL reset_depth got %0d want 0", depth); else passed++;
    checks++;
    if (RegWrite !== 1'b0) $display("FAIL reset_regwrite got %b want 0", RegWrite); else passed++;
    checks++;
    if (md_ready !== 1'b1) $display("FAIL reset_md_ready got %b want 1", md_ready); else passed++;
    checks++;
    if (qry_pending !== 1'b0) $display("FAIL reset_qry got %b want 0", qry_pending); else passed++;
  endtask

  task automatic test_single();
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234, 5'd5);
    checks++;
    if (depth !== 3'd1) $display("FAIL single_depth got %0d want 1", depth); else passed++;
    checks++;
    if (qry_pending !== 1'b1) $display("FAIL single_qry got %b want 1", qry_pending); else passed++;
    idle(5'd5);
    checks++;
    if ({RegWrite, Waddr, WData} !== {1'b1, 5'd5, 32'h1234})
      $display("FAIL single_write got we=%b addr=%0d data=%h want we=1 addr=5 data=1234",
               RegWrite, Waddr, WData);
    else passed++;
    checks++;
    if (depth !== 3'd0) $display("FAIL single_drain got %0d want 0", depth); else passed++;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, 5'(10 + i), 32'(i), 1'b1, 5'(i + 1), 32'(32'hF00 + i), 5'd0);
    checks++;
    if (depth !== 3'd4) $display("FAIL fill_depth got %0d want 4", depth); else passed++;
    checks++;
    if (md_ready !== 1'b0) $display("FAIL fill_ready got %b want 0", md_ready); else passed++;
    // Fifth result must be refused while the pipeline keeps the port busy.
    step(1'b0, 1'b1, 5'd20, 32'h5, 1'b1, 5'd9, 32'h999, 5'd9);
    checks++;
    if (depth !== 3'd4) $display("FAIL fill_no_push got %0d want 4", depth); else passed++;
    for (int i = 0; i < 4; i++) begin
      idle(5'd0);
      checks++;
      if ({RegWrite, Waddr, WData} !== {1'b1, 5'(i + 1), 32'(32'hF00 + i)})
        $display("FAIL fill_order got we=%b addr=%0d data=%h want addr=%0d",
                 RegWrite, Waddr, WData, i + 1);
      else passed++;
    end
  endtask

  task automatic test_kill();
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hAAAA, 5'd7);
    step(1'b0, 1'b1, 5'd7, 32'hBBBB, 1'b0, 5'd0, 32'd0, 5'd7);
    checks++;
    if ({RegWrite, Waddr, WData} !== {1'b1, 5'd7, 32'hBBBB})
      $display("FAIL kill_pipe got we=%b addr=%0d data=%h want we=1 addr=7 data=bbbb",
               RegWrite, Waddr, WData);
    else passed++;
    checks++;
    if (qry_pending !== 1'b0) $display("FAIL kill_qry got %b want 0", qry_pending); else passed++;
    idle(5'd7);
    checks++;
    if (RegWrite !== 1'b0) $display("FAIL kill_pop got %b want 0", RegWrite); else passed++;
  endtask

  task automatic test_reg0();
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h77, 5'd0);
    checks++;
    if (depth !== 3'd0) $display("FAIL reg0_md got %0d want 0", depth); else passed++;
    step(1'b0, 1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'd0, 5'd0);
    checks++;
    if (RegWrite !== 1'b0) $display("FAIL reg0_pipe got %b want 0", RegWrite); else passed++;
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h33, 5'd3);
    step(1'b0, 1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'd0, 5'd3);
    checks++;
    if ({RegWrite, Waddr, depth} !== {1'b1, 5'd3, 3'd0})
      $display("FAIL reg0_drain got we=%b addr=%0d depth=%0d want we=1 addr=3 depth=0",
               RegWrite, Waddr, depth);
    else passed++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, 5'd20, 32'd0, 1'b1, 5'(11 + i), 32'(i), 5'd0);
    // Full: the pop frees a slot but the result offered this cycle is refused.
    pipe_we = 1'b0; md_valid = 1'b1; md_addr = 5'd15; #1;
    checks++;
    if (md_ready !== 1'b0) $display("FAIL b2b_full_ready got %b want 0", md_ready); else passed++;
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd15, 32'h15, 5'd15);
    checks++;
    if (depth !== 3'd3) $display("FAIL b2b_full_depth got %0d want 3", depth); else passed++;
    idle(5'd0);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd16, 32'h16, 5'd16);
    checks++;
    if (depth !== 3'd2) $display("FAIL b2b_depth2 got %0d want 2", depth); else passed++;
    idle(5'd16);
    idle(5'd16);
  endtask

  task automatic test_same_addr();
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h0111, 5'd0);
    step(1'b0, 1'b1, 5'd6, 32'h0222, 1'b1, 5'd6, 32'h0333, 5'd6);
    checks++;
    if ({depth, qry_pending} !== {3'd2, 1'b1})
      $display("FAIL same_state got depth=%0d pend=%b want depth=2 pend=1", depth, qry_pending);
    else passed++;
    idle(5'd6);
    checks++;
    if (RegWrite !== 1'b0) $display("FAIL same_old got %b want 0", RegWrite); else passed++;
    idle(5'd6);
    checks++;
    if ({RegWrite, Waddr, WData} !== {1'b1, 5'd6, 32'h0333})
      $display("FAIL same_young got we=%b addr=%0d data=%h want we=1 addr=6 data=333",
               RegWrite, Waddr, WData);
    else passed++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 5'd20, 32'd0, 1'b1, 5'(i + 1), 32'(i), 5'd0);
    step(1'b1, 1'b1, 5'd9, 32'h9, 1'b1, 5'd4, 32'h4, 5'd1);
    checks++;
    if ({depth, RegWrite, md_ready, qry_pending} !== {3'd0, 1'b0, 1'b1, 1'b0})
      $display("FAIL rstmid got depth=%0d we=%b rdy=%b pend=%b want 0 0 1 0",
               depth, RegWrite, md_ready, qry_pending);
    else passed++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) == 0),
           5'($urandom_range(0, 7)), $urandom(), $urandom_range(0, 1) == 1,
           5'($urandom_range(0, 7)), $urandom(), 5'($urandom_range(0, 7)));
    end
  endtask

  initial begin
    reset = 1'b1; pipe_we = 1'b0; pipe_addr = '0; pipe_data = '0;
    md_valid = 1'b0; md_addr = '0; md_data = '0; qry_addr = '0;
    test_reset();
    test_single();
    test_fill();
    test_kill();
    test_reg0();
    test_back_to_back();
    test_same_addr();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/reg_wb_queue.md
REG_WB_QUEUE -- requirements
Module: reg_wb_queue

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 SHALL have port pipe_we, input, 1 bit: W-stage register write request.
REQ-004 SHALL have port pipe_addr, input, 5 bits: W-stage destination register.
REQ-005 SHALL have port pipe_data, input, 32 bits: W-stage write data.
REQ-006 SHALL have port md_valid, input, 1 bit: multiply/divide unit result valid.
REQ-007 SHALL have port md_addr, input, 5 bits: multiply/divide destination register.
REQ-008 SHALL have port md_data, input, 32 bits: multiply/divide result.
REQ-009 SHALL have port md_ready, output, 1 bit: the queue can accept a multiply/divide result.
REQ-010 SHALL have port RegWrite, output, 1 bit: register file write enable.
REQ-011 SHALL have port Waddr, output, 5 bits: register file write address.
REQ-012 SHALL have port WData, output, 32 bits: register file write data.
REQ-013 SHALL have port qry_addr, input, 5 bits: D-stage source register to check.
REQ-014 SHALL have port qry_pending, output, 1 bit: a valid queued write targets qry_addr.
REQ-015 SHALL have port depth, output, 3 bits: queue occupancy (0-4), counting all entries, valid or killed.

Function
REQ-016 SHALL hold a 4-entry FIFO; each entry is {valid, addr[4:0], data[31:0]}.
REQ-017 SHALL drive md_ready = (depth < 4) combinationally, independent of a same-cycle pop.
REQ-018 SHALL accept the md result when md_valid and md_ready are both 1 at a clock edge.
REQ-019 SHALL discard an accepted md result whose md_addr = 0, with no push.
REQ-020 SHALL push an accepted md result whose md_addr is nonzero at the tail with valid = 1.
REQ-021 SHALL ignore md_valid when md_ready = 0; the md unit holds its data until accepted.
REQ-022 SHALL register RegWrite, Waddr and WData, giving one cycle of latency from the request edge to the outputs.
REQ-023 SHALL update the outputs at each edge by priority; priority (a): if pipe_we = 1 and pipe_addr != 0, output {1, pipe_addr, pipe_data} and do not pop.
REQ-024 SHALL, at priority (b), when the queue is non-empty, pop the head and output {head.valid, head.addr, head.data}; a killed head gives RegWrite = 0.
REQ-025 SHALL, at priority (c), otherwise output RegWrite = 0, Waddr = 0, WData = 0.
REQ-026 SHALL treat pipe_we = 1 with pipe_addr = 0 as no request.
REQ-027 SHALL clear the valid bit of every existing entry with addr = pipe_addr when a pipeline write (REQ-023) occurs, so a stale result cannot overwrite a newer one.
REQ-028 SHALL push an md entry accepted in the same cycle as a pipeline write to the same address with valid = 1 (the md result is the younger write).
REQ-029 SHALL, on simultaneous push and pop, leave depth unchanged; FIFO order is preserved in all cases.
REQ-030 SHALL drive qry_pending = 1 iff qry_addr != 0 and some valid entry has addr = qry_addr (combinational), ignoring killed entries.
REQ-031 SHALL wrap its head and tail pointers modulo 4.

Reset
REQ-032 SHALL, on reset = 1 at an edge, empty the queue (depth = 0, all valid bits 0, pointers 0) and set RegWrite = 0, Waddr = 0, WData = 0.
REQ-033 SHALL give reset priority over every simultaneous push, pop or kill.
REQ-034 SHALL drive md_ready = 1 and qry_pending = 0 in the cycle after reset.

Verification
REQ-035 Single md write: md_valid = 1, md_addr = 5, md_data = 0x1234, no pipe writes -> one edge later depth = 1 and qry_pending = 1 for qry_addr = 5; next edge RegWrite = 1, Waddr = 5, WData = 0x1234; then depth = 0.
REQ-036 Fill: push md_addr = 1, 2, 3, 4 while pipe_we = 1 on distinct regs -> depth = 4, md_ready = 0, and a fifth md_valid is not accepted; after pipe_we = 0, the outputs show 1, 2, 3, 4 in order.
REQ-037 Kill: queue holds addr 7 (data 0xAAAA), then pipe write 7 = 0xBBBB -> Waddr = 7, WData = 0xBBBB; qry_pending(7) = 0; the later pop of the killed entry gives RegWrite = 0.
REQ-038 Register 0: md_addr = 0 accepted -> depth stays 0; pipe_we = 1 with pipe_addr = 0 -> RegWrite = 0 and a queued entry drains.
REQ-039 Simultaneous push and pop at depth = 4 -> md_ready = 0 and no push; at depth = 2 -> depth stays 2.
REQ-040 Reset with depth = 3 -> next cycle depth = 0, RegWrite = 0, md_ready = 1, qry_pending = 0.
